mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one memory block between two requesters: port A (CPU) and port B (audio/DMA engine).
- The memory block has 16-bit read and write addresses, a WIDTH-bit write port with write enable, and an always-enabled read port with fixed latency.
- The arbiter grants at most one access per cycle using round-robin, registers the memory-side command, and routes returning read data back to the owner via a tag pipeline.

Parameters:
- WIDTH, 16, data bit width of memory and requesters.
- RD_LAT, 1, memory read latency in cycles from mem_rd_addr registered to mem_rd_data valid. Legal range 1 to 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a_req  input  1  port A request; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we  input  1  1 = write, 0 = read.
- a_addr  input  16  access address.
- a_wdata  input  WIDTH  write data.
- a_gnt  output  1  combinational; request accepted this cycle.
- a_rvalid  output  1  read data for port A present on a_rdata.
- a_rdata  output  WIDTH  read data (passthrough of mem_rd_data).
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical set for port B.
- mem_wr_addr  output  16  memory write address.
- mem_rd_addr  output  16  memory read address.
- mem_wr_enable  output  1  memory write strobe.
- mem_wr_data  output  WIDTH  memory write data.
- mem_rd_data  input  WIDTH  memory read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port rst.
- Reset values:
  - mem_wr_enable = 0; mem_wr_addr, mem_rd_addr, mem_wr_data = 0.
  - Tag pipeline cleared; a_rvalid = b_rvalid = 0.
  - Round-robin pointer = A (A wins the first tie).
- Arbitration, combinational:
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: the side not granted most recently wins.
  - Pointer updates on the clock edge after any grant. No grant leaves the pointer unchanged.
  - Never both gnt in one cycle; gnt is never asserted without req.
- Issue, registered: a grant in cycle T drives the memory side in cycle T+1.
  - Write: mem_wr_enable = 1, with mem_wr_addr and mem_wr_data taken from the winner.
  - Read: mem_rd_addr = winner's addr, mem_wr_enable = 0.
- Idle cycles: mem_wr_enable = 0; mem_rd_addr and mem_wr_addr hold their last values.
- Read return:
  - Tag shift register of depth RD_LAT+1; each entry is {valid, owner}. The entry is pushed on every cycle in which a read is granted.
  - Data for a read granted in cycle T appears on mem_rd_data in cycle T+1+RD_LAT.
  - In that same cycle, the owner's rvalid = 1 for exactly one cycle; the other port's rvalid = 0.
  - a_rdata and b_rdata both equal mem_rd_data at all times; rvalid qualifies them.
- Throughput and ordering:
  - Back-to-back grants are allowed every cycle, so reads pipeline at full rate.
  - Returns arrive in grant order.
  - No write forwarding: read-after-write ordering is whatever the memory provides once the write is issued.
- Requester protocol violation: if req drops before gnt, nothing is issued.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset), and any pending write in the issue register is cancelled.

Optional Feature:
- MEM_ARB_LOCK_EN: adds input ports a_lock and b_lock (1 bit each).
  - While the current lock owner holds its lock, it is the sole grantable port. The lock owner is the port that was granted with its lock high.
  - The other port's req is ignored even when the owner is idle.
  - Lock releases on the first cycle the owner's lock is low. After release, normal round-robin resumes with the pointer favouring the non-owner.
  - Reset clears lock ownership.
- Without MEM_ARB_LOCK_EN: no lock ports; pure round-robin as above.

Test Plan:
- Reset, then A write: a_req=1, a_we=1, a_addr=0x0010, a_wdata=0xBEEF.
  - Expect a_gnt=1 the same cycle, then mem_wr_enable=1, mem_wr_addr=0x0010, mem_wr_data=0xBEEF the next cycle.
- A read of 0x0010 with RD_LAT=1 and memory model returning 0xBEEF.
  - Expect a_rvalid=1 and a_rdata=0xBEEF exactly 2 cycles after a_gnt; b_rvalid stays 0.
- A and B both requesting reads continuously for 6 cycles.
  - Expect grants A,B,A,B,A,B, and rvalid alternating A,B,… each RD_LAT+1 cycles after its grant.
- B alone issues 4 back-to-back reads to 0x0001..0x0004 with RD_LAT=3.
  - Expect b_rvalid high for 4 consecutive cycles, data in address order.
- Assert rst while 2 reads are in flight.
  - Expect no rvalid pulse after reset, mem_wr_enable=0, and the next simultaneous request granted to A.
- MEM_ARB_LOCK_EN: B is granted with b_lock=1 and holds lock for 3 cycles while a_req=1.
  - Expect a_gnt=0 throughout.
  - After b_lock falls, expect a_gnt=1 on the first cycle lock is low, even if b_req=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bundles for mem_arbiter.
// MEM_ARB_LOCK_EN adds a per-requester lock line to the requester bundle.

// One requester port: request/grant handshake plus the read return path.
interface mem_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req;
    logic             we;
    logic [15:0]      addr;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
`ifdef MEM_ARB_LOCK_EN
    logic             lock;

    modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid, rdata);
`else
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
`endif
endinterface

// Memory block port: separate write and read addresses, fixed-latency read.
interface mem_arbiter_mem_if #(
    parameter int WIDTH = 16
);
    logic [15:0]      wr_addr;
    logic [15:0]      rd_addr;
    logic             wr_enable;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;

    modport master (output wr_addr, rd_addr, wr_enable, wr_data, input rd_data);
    modport slave  (input wr_addr, rd_addr, wr_enable, wr_data, output rd_data);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory block between port A (CPU) and
// port B (audio/DMA). One access is granted per cycle, the memory command is
// registered, and read data is steered back to its owner by a tag pipeline
// of depth RD_LAT+1.
// Optional feature macro: MEM_ARB_LOCK_EN (per-port lock for exclusive access).

module mem_arbiter #(
    parameter int WIDTH  = 16,
    parameter int RD_LAT = 1     // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      a,
    mem_arbiter_if.slave      b,
    mem_arbiter_mem_if.master mem
);

    localparam int TAG_DEPTH = RD_LAT + 1;

    // ptr_reg = 0: A wins a tie; ptr_reg = 1: B wins a tie.
    logic             ptr_reg;
    logic             req_a_eff;
    logic             req_b_eff;
    logic             favour_a;
    logic             gnt_a;
    logic             gnt_b;
    logic             gnt_any;
    logic             gnt_we;
    logic [15:0]      gnt_addr;
    logic [WIDTH-1:0] gnt_wdata;

    logic             wr_enable_reg;
    logic [15:0]      wr_addr_reg;
    logic [15:0]      rd_addr_reg;
    logic [WIDTH-1:0] wr_data_reg;

    // Each tag entry is {valid, owner}; owner 0 = A, 1 = B.
    logic [TAG_DEPTH-1:0] tag_valid_reg;
    logic [TAG_DEPTH-1:0] tag_valid_next;
    logic [TAG_DEPTH-1:0] tag_owner_reg;
    logic [TAG_DEPTH-1:0] tag_owner_next;

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        LOCK_NONE,
        LOCK_A,
        LOCK_B
    } lock_state_t;

    lock_state_t lock_state_reg;
    lock_state_t lock_state_next;
    logic        held_a;
    logic        held_b;

    // Lock gating: a holding owner masks the other port; on release the tie goes to the non-owner.
    always_comb begin
        held_a    = (lock_state_reg == LOCK_A) && a.lock;
        held_b    = (lock_state_reg == LOCK_B) && b.lock;
        req_a_eff = a.req && !held_b;
        req_b_eff = b.req && !held_a;
        favour_a  = ~ptr_reg;
        if ((lock_state_reg == LOCK_A) && !a.lock) begin
            favour_a = 1'b0;
        end else if ((lock_state_reg == LOCK_B) && !b.lock) begin
            favour_a = 1'b1;
        end
    end

    // Lock ownership next state: taken by a grant with lock high, kept while held.
    always_comb begin
        lock_state_next = LOCK_NONE;
        if (gnt_a && a.lock) begin
            lock_state_next = LOCK_A;
        end else if (gnt_b && b.lock) begin
            lock_state_next = LOCK_B;
        end else if (held_a) begin
            lock_state_next = LOCK_A;
        end else if (held_b) begin
            lock_state_next = LOCK_B;
        end
    end

    // Lock ownership state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state_reg <= LOCK_NONE;
        end else begin
            lock_state_reg <= lock_state_next;
        end
    end
`else
    // Without locking, requests pass straight to the round-robin stage.
    always_comb begin
        req_a_eff = a.req;
        req_b_eff = b.req;
        favour_a  = ~ptr_reg;
    end
`endif

    // Round-robin selection and mux of the winner's command.
    always_comb begin
        gnt_a     = req_a_eff && (!req_b_eff || favour_a);
        gnt_b     = req_b_eff && !gnt_a;
        gnt_any   = gnt_a || gnt_b;
        gnt_we    = gnt_a ? a.we    : b.we;
        gnt_addr  = gnt_a ? a.addr  : b.addr;
        gnt_wdata = gnt_a ? a.wdata : b.wdata;
    end

    assign a.gnt = gnt_a;
    assign b.gnt = gnt_b;

    // Pointer points away from the most recent winner; idle cycles leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (gnt_any) begin
            ptr_reg <= gnt_a;
        end
    end

    // Issue register: the winner's command reaches the memory one cycle after grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_enable_reg <= 1'b0;
            wr_addr_reg   <= '0;
            rd_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            wr_enable_reg <= gnt_any && gnt_we;
            if (gnt_any && gnt_we) begin
                wr_addr_reg <= gnt_addr;
                wr_data_reg <= gnt_wdata;
            end
            if (gnt_any && !gnt_we) begin
                rd_addr_reg <= gnt_addr;
            end
        end
    end

    assign mem.wr_enable = wr_enable_reg;
    assign mem.wr_addr   = wr_addr_reg;
    assign mem.rd_addr   = rd_addr_reg;
    assign mem.wr_data   = wr_data_reg;

    // Tag pipeline: stage 0 takes this cycle's read grant, later stages shift.
    assign tag_valid_next[0] = gnt_any && !gnt_we;
    assign tag_owner_next[0] = gnt_b;

    genvar gi;
    generate
        for (gi = 1; gi < TAG_DEPTH; gi++) begin : g_tag_shift
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
            assign tag_owner_next[gi] = tag_owner_reg[gi-1];
        end
    endgenerate

    // Tag register: reset discards every read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_owner_reg <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_owner_reg <= tag_owner_next;
        end
    end

    // The last tag stage lines up with mem.rd_data and picks the owner.
    assign a.rvalid = tag_valid_reg[RD_LAT] && !tag_owner_reg[RD_LAT];
    assign b.rvalid = tag_valid_reg[RD_LAT] &&  tag_owner_reg[RD_LAT];
    assign a.rdata  = mem.rd_data;
    assign b.rdata  = mem.rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: dut1 uses RD_LAT=1, dut3 uses RD_LAT=3.
// Stimulus pushes expected returns/writes with their due cycle; a monitor on
// the falling edge pops and compares whenever the DUT presents an output.
// Lock scenarios are exercised when MEM_ARB_LOCK_EN is defined.

module tb_mem_arbiter;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } rd_exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    rd_exp_t qa1[$];
    rd_exp_t qb1[$];
    rd_exp_t qa3[$];
    rd_exp_t qb3[$];
    wr_exp_t qw1[$];
    rd_exp_t re;
    wr_exp_t we_e;

    mem_arbiter_if     #(.WIDTH(16)) ra1 ();
    mem_arbiter_if     #(.WIDTH(16)) rb1 ();
    mem_arbiter_mem_if #(.WIDTH(16)) m1 ();
    mem_arbiter_if     #(.WIDTH(16)) ra3 ();
    mem_arbiter_if     #(.WIDTH(16)) rb3 ();
    mem_arbiter_mem_if #(.WIDTH(16)) m3 ();

    mem_arbiter #(.WIDTH(16), .RD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .a   (ra1),
        .b   (rb1),
        .mem (m1)
    );

    mem_arbiter #(.WIDTH(16), .RD_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .a   (ra3),
        .b   (rb3),
        .mem (m3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: unwritten location X reads as 16'h1000 | X.
    bit          wr_flag1 [256];
    logic [15:0] mem1     [256];
    logic [15:0] pipe1;
    bit          wr_flag3 [256];
    logic [15:0] mem3     [256];
    logic [15:0] pipe3    [3];

    always @(posedge clk) begin
        if (m1.wr_enable) begin
            mem1[m1.wr_addr[7:0]]     <= m1.wr_data;
            wr_flag1[m1.wr_addr[7:0]] <= 1'b1;
        end
        pipe1 <= wr_flag1[m1.rd_addr[7:0]] ? mem1[m1.rd_addr[7:0]] : (16'h1000 | m1.rd_addr);
    end

    always @(posedge clk) begin
        if (m3.wr_enable) begin
            mem3[m3.wr_addr[7:0]]     <= m3.wr_data;
            wr_flag3[m3.wr_addr[7:0]] <= 1'b1;
        end
        pipe3[0] <= wr_flag3[m3.rd_addr[7:0]] ? mem3[m3.rd_addr[7:0]] : (16'h1000 | m3.rd_addr);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign m1.rd_data = pipe1;
    assign m3.rd_data = pipe3[2];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input bit ar, input bit aw, input logic [15:0] aa, input logic [15:0] ad,
                        input bit br, input bit bw, input logic [15:0] ba, input logic [15:0] bd);
        ra1.req = ar; ra1.we = aw; ra1.addr = aa; ra1.wdata = ad;
        rb1.req = br; rb1.we = bw; rb1.addr = ba; rb1.wdata = bd;
    endtask

    task automatic set3(input bit ar, input bit aw, input logic [15:0] aa, input logic [15:0] ad,
                        input bit br, input bit bw, input logic [15:0] ba, input logic [15:0] bd);
        ra3.req = ar; ra3.we = aw; ra3.addr = aa; ra3.wdata = ad;
        rb3.req = br; rb3.we = bw; rb3.addr = ba; rb3.wdata = bd;
    endtask

    task automatic chk_gnt1(input string n, input bit ea, input bit eb);
        chk({n, "_a_gnt"}, 32'(ra1.gnt), 32'(ea));
        chk({n, "_b_gnt"}, 32'(rb1.gnt), 32'(eb));
    endtask

    task automatic chk_gnt3(input string n, input bit ea, input bit eb);
        chk({n, "_a_gnt"}, 32'(ra3.gnt), 32'(ea));
        chk({n, "_b_gnt"}, 32'(rb3.gnt), 32'(eb));
    endtask

    // Monitor: pop on every presented output, flag outputs nobody expected and expectations that came due unmet.
    always @(negedge clk) begin
        if (ra1.rvalid) begin
            if (qa1.size() == 0) chk("a1_unexpected_rvalid", 32'(ra1.rvalid), 0);
            else begin
                re = qa1.pop_front();
                chk("a1_rvalid_cycle", cyc, re.cyc);
                chk("a1_rdata", 32'(ra1.rdata), 32'(re.data));
            end
        end else if (qa1.size() != 0 && qa1[0].cyc <= cyc) begin
            re = qa1.pop_front();
            chk("a1_missing_rvalid", 32'(ra1.rvalid), 1);
        end

        if (rb1.rvalid) begin
            if (qb1.size() == 0) chk("b1_unexpected_rvalid", 32'(rb1.rvalid), 0);
            else begin
                re = qb1.pop_front();
                chk("b1_rvalid_cycle", cyc, re.cyc);
                chk("b1_rdata", 32'(rb1.rdata), 32'(re.data));
            end
        end else if (qb1.size() != 0 && qb1[0].cyc <= cyc) begin
            re = qb1.pop_front();
            chk("b1_missing_rvalid", 32'(rb1.rvalid), 1);
        end

        if (m1.wr_enable) begin
            if (qw1.size() == 0) chk("m1_unexpected_write", 32'(m1.wr_enable), 0);
            else begin
                we_e = qw1.pop_front();
                chk("m1_write_cycle", cyc, we_e.cyc);
                chk("m1_wr_addr", 32'(m1.wr_addr), 32'(we_e.addr));
                chk("m1_wr_data", 32'(m1.wr_data), 32'(we_e.data));
            end
        end else if (qw1.size() != 0 && qw1[0].cyc <= cyc) begin
            we_e = qw1.pop_front();
            chk("m1_missing_write", 32'(m1.wr_enable), 1);
        end

        if (ra3.rvalid) begin
            if (qa3.size() == 0) chk("a3_unexpected_rvalid", 32'(ra3.rvalid), 0);
            else begin
                re = qa3.pop_front();
                chk("a3_rvalid_cycle", cyc, re.cyc);
                chk("a3_rdata", 32'(ra3.rdata), 32'(re.data));
            end
        end else if (qa3.size() != 0 && qa3[0].cyc <= cyc) begin
            re = qa3.pop_front();
            chk("a3_missing_rvalid", 32'(ra3.rvalid), 1);
        end

        if (rb3.rvalid) begin
            if (qb3.size() == 0) chk("b3_unexpected_rvalid", 32'(rb3.rvalid), 0);
            else begin
                re = qb3.pop_front();
                chk("b3_rvalid_cycle", cyc, re.cyc);
                chk("b3_rdata", 32'(rb3.rdata), 32'(re.data));
            end
        end else if (qb3.size() != 0 && qb3[0].cyc <= cyc) begin
            re = qb3.pop_front();
            chk("b3_missing_rvalid", 32'(rb3.rvalid), 1);
        end
    end

    initial begin
        int ia;
        int ib;
        set1(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        set3(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
`ifdef MEM_ARB_LOCK_EN
        ra1.lock = 1'b0; rb1.lock = 1'b0; ra3.lock = 1'b0; rb3.lock = 1'b0;
`endif
        // Reset state
        step();
        step();
        chk("rst_wr_enable", 32'(m1.wr_enable), 0);
        chk("rst_wr_addr",   32'(m1.wr_addr), 0);
        chk("rst_rd_addr",   32'(m1.rd_addr), 0);
        chk("rst_wr_data",   32'(m1.wr_data), 0);
        chk("rst_a_rvalid",  32'(ra1.rvalid), 0);
        chk("rst_b_rvalid",  32'(rb1.rvalid), 0);
        rst = 1'b0;

        // A write 0x0010 <= 0xBEEF
        step();
        set1(1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0);
        #1;
        chk_gnt1("a_write", 1, 0);
        qw1.push_back('{cyc + 1, 16'h0010, 16'hBEEF});
        $display("txn cycle=%0d A write addr=0010 data=BEEF", cyc);

        // A read 0x0010, data two cycles after grant
        step();
        set1(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
        #1;
        chk_gnt1("a_read", 1, 0);
        qa1.push_back('{cyc + 2, 16'hBEEF});
        $display("txn cycle=%0d A read addr=0010 expect=BEEF", cyc);

        // B alone read 0x0031 (leaves the pointer favouring A)
        step();
        set1(0, 0, 16'h0, 16'h0, 1, 0, 16'h0031, 16'h0);
        #1;
        chk_gnt1("b_read", 0, 1);
        qb1.push_back('{cyc + 2, 16'h1031});
        $display("txn cycle=%0d B read addr=0031 expect=1031", cyc);

        // Both request reads for 6 cycles: grants alternate A,B,A,B,A,B
        ia = 0;
        ib = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            set1(1, 0, 16'(32'h20 + ia), 16'h0, 1, 0, 16'(32'h30 + ib), 16'h0);
            #1;
            chk_gnt1("alternate", (k % 2) == 0, (k % 2) == 1);
            if ((k % 2) == 0) begin
                qa1.push_back('{cyc + 2, 16'(32'h1020 + ia)});
                $display("txn cycle=%0d A read addr=%h expect=%h", cyc, 16'(32'h20 + ia), 16'(32'h1020 + ia));
                ia++;
            end else begin
                qb1.push_back('{cyc + 2, 16'(32'h1030 + ib)});
                $display("txn cycle=%0d B read addr=%h expect=%h", cyc, 16'(32'h30 + ib), 16'(32'h1030 + ib));
                ib++;
            end
        end
        step();
        set1(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

`ifdef MEM_ARB_LOCK_EN
        // B takes the lock, A is shut out until b_lock falls
        step();
        rb1.lock = 1'b1;
        set1(0, 0, 16'h0, 16'h0, 1, 0, 16'h0035, 16'h0);
        #1;
        chk_gnt1("lock_take", 0, 1);
        qb1.push_back('{cyc + 2, 16'h1035});
        $display("txn cycle=%0d B locked read addr=0035 expect=1035", cyc);
        for (int k = 0; k < 3; k++) begin
            step();
            set1(1, 0, 16'h0025, 16'h0, k == 0, 0, 16'h0036, 16'h0);
            #1;
            chk_gnt1("lock_hold", 0, k == 0);
            if (k == 0) qb1.push_back('{cyc + 2, 16'h1036});
            $display("txn cycle=%0d lock held, A request blocked", cyc);
        end
        step();
        rb1.lock = 1'b0;
        set1(1, 0, 16'h0025, 16'h0, 1, 0, 16'h0037, 16'h0);
        #1;
        chk_gnt1("lock_release", 1, 0);
        qa1.push_back('{cyc + 2, 16'h1025});
        $display("txn cycle=%0d lock released, A read addr=0025 expect=1025", cyc);
        step();
        set1(0, 0, 16'h0, 16'h0, 1, 0, 16'h0037, 16'h0);
        #1;
        chk_gnt1("after_release", 0, 1);
        qb1.push_back('{cyc + 2, 16'h1037});
        step();
        set1(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
`endif

        // RD_LAT=3: B issues 4 back-to-back reads, returns on 4 consecutive cycles
        for (int k = 0; k < 4; k++) begin
            step();
            set3(0, 0, 16'h0, 16'h0, 1, 0, 16'(k + 1), 16'h0);
            #1;
            chk_gnt3("b_burst", 0, 1);
            qb3.push_back('{cyc + 4, 16'(32'h1001 + k)});
            $display("txn cycle=%0d B read addr=%h expect=%h (RD_LAT=3)", cyc, 16'(k + 1), 16'(32'h1001 + k));
        end
        step();
        set3(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        repeat (6) step();

        // Two reads in flight plus a pending write, then reset
        set3(0, 0, 16'h0, 16'h0, 1, 0, 16'h0005, 16'h0);
        #1;
        chk_gnt3("pre_rst_b0", 0, 1);
        step();
        set3(0, 0, 16'h0, 16'h0, 1, 0, 16'h0006, 16'h0);
        #1;
        chk_gnt3("pre_rst_b1", 0, 1);
        step();
        set3(1, 1, 16'h0040, 16'h1234, 0, 0, 16'h0, 16'h0);
        #1;
        chk_gnt3("pre_rst_aw", 1, 0);
        step();
        set3(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        chk("pre_rst_wr_enable", 32'(m3.wr_enable), 1);
        rst = 1'b1;
        #1;
        $display("txn cycle=%0d reset asserted with 2 reads in flight", cyc);
        chk("rst_mid_wr_enable", 32'(m3.wr_enable), 0);
        chk("rst_mid_rd_addr",   32'(m3.rd_addr), 0);
        qa1.delete(); qb1.delete(); qw1.delete(); qa3.delete(); qb3.delete();
        step();
        step();
        rst = 1'b0;
        repeat (6) step();

        // After reset the pointer is back on A
        set3(1, 0, 16'h0050, 16'h0, 1, 0, 16'h0051, 16'h0);
        #1;
        chk_gnt3("post_rst_tie", 1, 0);
        qa3.push_back('{cyc + 4, 16'h1050});
        $display("txn cycle=%0d post-reset tie, A read addr=0050 expect=1050", cyc);
        step();
        set3(0, 0, 16'h0, 16'h0, 1, 0, 16'h0051, 16'h0);
        #1;
        chk_gnt3("post_rst_b", 0, 1);
        qb3.push_back('{cyc + 4, 16'h1051});
        $display("txn cycle=%0d B read addr=0051 expect=1051", cyc);
        step();
        set3(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

        // Drain and confirm every expected response was seen
        repeat (8) step();
        chk("drain_qa1", qa1.size(), 0);
        chk("drain_qb1", qb1.size(), 0);
        chk("drain_qw1", qw1.size(), 0);
        chk("drain_qa3", qa3.size(), 0);
        chk("drain_qb3", qb3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
